// File: rtl/lc3_decode_pkg.sv
// Shared types and field encodings for the LC3 decode stage.
// e_control_t bit order: {alu_ctl[1:0], pcsel1[1:0], pcsel2, op2sel}.
package lc3_decode_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RSVD = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PCSEL1_NONE = 2'b00;
  localparam logic [1:0] PCSEL1_OFF9 = 2'b01;
  localparam logic [1:0] PCSEL1_OFF6 = 2'b10;
  localparam logic [1:0] PCSEL1_BASE = 2'b11;

  localparam logic [1:0] W_ALUOUT = 2'b00;
  localparam logic [1:0] W_MEMOUT = 2'b01;
  localparam logic [1:0] W_PCOUT  = 2'b10;

  typedef struct packed {
    logic [1:0] alu_ctl;
    logic [1:0] pcsel1;
    logic       pcsel2;
    logic       op2sel;
  } e_control_t;

endpackage

// File: rtl/lc3_decode_ctrl_lut.sv
// Combinational opcode decoder: instruction word to execute/writeback/memory
// control words plus an unsupported-opcode flag.
module lc3_decode_ctrl_lut
  import lc3_decode_pkg::*;
(
  input  logic [15:0] instr,
  output logic [5:0]  e_control,
  output logic [1:0]  w_control,
  output logic        m_control,
  output logic        illegal
);

  e_control_t e;
  logic       unused_bits;

  assign unused_bits = &{1'b0, instr[11:6], instr[4:0]};

  always_comb begin
    e       = '0;
    w_control = W_ALUOUT;
    m_control = 1'b0;
    illegal   = 1'b0;
    case (instr[15:12])
      OP_ADD: begin
        e.alu_ctl = ALU_ADD;
        e.op2sel  = ~instr[5];
      end
      OP_AND: begin
        e.alu_ctl = ALU_AND;
        e.op2sel  = ~instr[5];
      end
      OP_NOT: e.alu_ctl = ALU_NOT;
      OP_BR: begin
        e.pcsel1 = PCSEL1_OFF9;
        e.pcsel2 = 1'b1;
      end
      OP_JMP: e.pcsel1 = PCSEL1_BASE;
      OP_LD, OP_LDI, OP_ST, OP_STI, OP_LEA: begin
        e.pcsel1 = PCSEL1_OFF9;
        e.pcsel2 = 1'b1;
        if (instr[15:12] == OP_LD || instr[15:12] == OP_LDI)
          w_control = W_MEMOUT;
        else if (instr[15:12] == OP_LEA)
          w_control = W_PCOUT;
        m_control = (instr[15:12] == OP_LDI) || (instr[15:12] == OP_STI);
      end
      OP_LDR, OP_STR: begin
        e.pcsel1 = PCSEL1_OFF6;
        if (instr[15:12] == OP_LDR)
          w_control = W_MEMOUT;
      end
      OP_JSR, OP_RTI, OP_RSVD, OP_TRAP: illegal = 1'b1;
      // Unknown opcode bits land here and yield all-zero controls.
      default: illegal = 1'b1;
    endcase
  end

  assign e_control = e;

endmodule

// File: rtl/lc3_decode_stage.sv
// LC3 decode pipeline stage: registers the fetched instruction, its next PC
// and the decoded control words, with valid and illegal-opcode status.
module lc3_decode_stage
  import lc3_decode_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_decode,
  input  logic [ADDR_W-1:0] instr,
  input  logic [ADDR_W-1:0] npc_in,
  output logic [ADDR_W-1:0] ir,
  output logic [ADDR_W-1:0] npc_out,
  output logic [5:0]        e_control,
  output logic [1:0]        w_control,
  output logic              m_control,
  output logic              out_valid,
  output logic              illegal_op
);

  logic [5:0] lut_e;
  logic [1:0] lut_w;
  logic       lut_m;
  logic       lut_ill;

  lc3_decode_ctrl_lut u_lut (
    .instr     (instr[15:0]),
    .e_control (lut_e),
    .w_control (lut_w),
    .m_control (lut_m),
    .illegal   (lut_ill)
  );

  logic [ADDR_W-1:0] ir_q, ir_d, npc_q, npc_d;
  logic [5:0]        e_q, e_d;
  logic [1:0]        w_q, w_d;
  logic              m_q, m_d, vld_q, vld_d, ill_q, ill_d;

  always_comb begin
    ir_d  = ir_q;
    npc_d = npc_q;
    e_d   = e_q;
    w_d   = w_q;
    m_d   = m_q;
    ill_d = ill_q;
    vld_d = 1'b0;
    if (enable_decode) begin
      ir_d  = instr;
      npc_d = npc_in;
      e_d   = lut_e;
      w_d   = lut_w;
      m_d   = lut_m;
      ill_d = lut_ill;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q  <= '0;
      npc_q <= '0;
      e_q   <= '0;
      w_q   <= '0;
      m_q   <= 1'b0;
      vld_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      ir_q  <= ir_d;
      npc_q <= npc_d;
      e_q   <= e_d;
      w_q   <= w_d;
      m_q   <= m_d;
      vld_q <= vld_d;
      ill_q <= ill_d;
    end
  end

  assign ir         = ir_q;
  assign npc_out    = npc_q;
  assign e_control  = e_q;
  assign w_control  = w_q;
  assign m_control  = m_q;
  assign out_valid  = vld_q;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Scoreboard bench for lc3_decode_stage with an independent decode-table model.
module tb_lc3_decode_stage;

  logic        clock, reset, enable_decode;
  logic [15:0] instr, npc_in, ir, npc_out;
  logic [5:0]  e_control;
  logic [1:0]  w_control;
  logic        m_control, out_valid, illegal_op;

  int total = 0;
  int bad   = 0;

  logic [42:0] sb[$];
  logic [42:0] exp_v;

  logic [15:0] m_ir, m_npc;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_m, m_ov, m_ill;

  lc3_decode_stage #(.ADDR_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .instr         (instr),
    .npc_in        (npc_in),
    .ir            (ir),
    .npc_out       (npc_out),
    .e_control     (e_control),
    .w_control     (w_control),
    .m_control     (m_control),
    .out_valid     (out_valid),
    .illegal_op    (illegal_op)
  );

  always #5 clock = ~clock;

  // Returns {e[5:0], w[1:0], m, illegal}.
  function automatic logic [9:0] ref_ctrl(input logic [15:0] i);
    case (i[15:12])
      4'b0001: return {4'b0000, 1'b0, ~i[5], 2'b00, 1'b0, 1'b0};
      4'b0101: return {4'b0100, 1'b0, ~i[5], 2'b00, 1'b0, 1'b0};
      4'b1001: return {6'b100000, 2'b00, 1'b0, 1'b0};
      4'b0000: return {6'b000110, 2'b00, 1'b0, 1'b0};
      4'b1100: return {6'b001100, 2'b00, 1'b0, 1'b0};
      4'b0010: return {6'b000110, 2'b01, 1'b0, 1'b0};
      4'b1010: return {6'b000110, 2'b01, 1'b1, 1'b0};
      4'b0011: return {6'b000110, 2'b00, 1'b0, 1'b0};
      4'b1011: return {6'b000110, 2'b00, 1'b1, 1'b0};
      4'b1110: return {6'b000110, 2'b10, 1'b0, 1'b0};
      4'b0110: return {6'b001000, 2'b01, 1'b0, 1'b0};
      4'b0111: return {6'b001000, 2'b00, 1'b0, 1'b0};
      default: return {6'b000000, 2'b00, 1'b0, 1'b1};
    endcase
  endfunction

  function automatic logic [42:0] obs();
    return {ir, npc_out, e_control, w_control, m_control, out_valid, illegal_op};
  endfunction

  task automatic model_clear();
    m_ir = '0; m_npc = '0; m_e = '0; m_w = '0; m_m = 0; m_ov = 0; m_ill = 0;
    sb.delete();
  endtask

  // Drives one cycle from a falling edge, records the prediction, and
  // returns on the next falling edge with the registered result visible.
  task automatic drive(input logic en, input logic [15:0] ins, input logic [15:0] np);
    logic [9:0] c;
    enable_decode = en;
    instr = ins;
    npc_in = np;
    if (en) begin
      c = ref_ctrl(ins);
      m_ir = ins; m_npc = np;
      m_e = c[9:4]; m_w = c[3:2]; m_m = c[1]; m_ill = c[0];
      m_ov = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
    sb.push_back({m_ir, m_npc, m_e, m_w, m_m, m_ov, m_ill});
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (obs() !== 43'd0) begin
      bad++; $display("FAIL reset_async got=%h want=%h", obs(), 43'd0);
    end
    repeat (2) @(negedge clock);
    total++;
    if (obs() !== 43'd0) begin
      bad++; $display("FAIL reset_held got=%h want=%h", obs(), 43'd0);
    end
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_add_reg();
    drive(1'b1, 16'h1283, 16'h3000);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL add_reg got=%h want=%h", obs(), exp_v);
    end
    total++;
    if ({e_control, w_control, m_control, ir, out_valid} !== {6'b000001, 2'b00, 1'b0, 16'h1283, 1'b1}) begin
      bad++; $display("FAIL add_reg_fields got=%h want=%h",
        {e_control, w_control, m_control, ir, out_valid}, {6'b000001, 2'b00, 1'b0, 16'h1283, 1'b1});
    end
  endtask

  task automatic test_add_imm();
    drive(1'b1, 16'h1262, 16'h3001);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL add_imm got=%h want=%h", obs(), exp_v);
    end
  endtask

  task automatic test_ldi();
    drive(1'b1, 16'hA405, 16'h3001);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL ldi got=%h want=%h", obs(), exp_v);
    end
    total++;
    if ({e_control, w_control, m_control, npc_out} !== {6'b000110, 2'b01, 1'b1, 16'h3001}) begin
      bad++; $display("FAIL ldi_fields got=%h want=%h",
        {e_control, w_control, m_control, npc_out}, {6'b000110, 2'b01, 1'b1, 16'h3001});
    end
  endtask

  task automatic test_ldr_hold();
    drive(1'b1, 16'h6A82, 16'h3002);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL ldr_load got=%h want=%h", obs(), exp_v);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'hE1FF, 16'h4000 + 16'(k));
      exp_v = sb.pop_front();
      total++;
      if (obs() !== exp_v) begin
        bad++; $display("FAIL ldr_hold%0d got=%h want=%h", k, obs(), exp_v);
      end
    end
    total++;
    if ({e_control, w_control, out_valid} !== {6'b001000, 2'b01, 1'b0}) begin
      bad++; $display("FAIL ldr_hold_fields got=%h want=%h",
        {e_control, w_control, out_valid}, {6'b001000, 2'b01, 1'b0});
    end
  endtask

  task automatic test_trap();
    drive(1'b1, 16'hF025, 16'h3003);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL trap got=%h want=%h", obs(), exp_v);
    end
    total++;
    if ({illegal_op, e_control, w_control, m_control, ir} !== {1'b1, 6'd0, 2'd0, 1'b0, 16'hF025}) begin
      bad++; $display("FAIL trap_fields got=%h want=%h",
        {illegal_op, e_control, w_control, m_control, ir}, {1'b1, 6'd0, 2'd0, 1'b0, 16'hF025});
    end
    drive(1'b0, 16'h1283, 16'h3004);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL trap_ill_hold got=%h want=%h", obs(), exp_v);
    end
    drive(1'b1, 16'h1283, 16'h3004);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v || illegal_op !== 1'b0) begin
      bad++; $display("FAIL trap_clear got=%h want=%h", obs(), exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins;
    for (int op = 0; op < 16; op++) begin
      ins = {4'(op), 12'($urandom)};
      drive(1'b1, ins, 16'($urandom));
      exp_v = sb.pop_front();
      total++;
      if (obs() !== exp_v) begin
        bad++; $display("FAIL b2b_op%0d got=%h want=%h", op, obs(), exp_v);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 16'hB1C3, 16'h5555);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL pre_reset got=%h want=%h", obs(), exp_v);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (obs() !== 43'd0) begin
      bad++; $display("FAIL mid_reset got=%h want=%h", obs(), 43'd0);
    end
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 16'h5A7F, 16'h3100);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL post_reset got=%h want=%h", obs(), exp_v);
    end
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b0;
    enable_decode = 1'b0;
    instr = '0;
    npc_in = '0;
    test_reset();
    test_add_reg();
    test_add_imm();
    test_ldi();
    test_ldr_hold();
    test_trap();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
